my_dmux16_stream: RTL

//  Streaming 1-to-2 demultiplexer for 16-bit words; the inverse of the 16-bit 2:1 mux.
//  - One input channel with valid/ready handshake.
//  - Each word is steered by in_sel to one of two output channels.
//  - Each output has its own small FIFO, so a stalled consumer does not block the

---
 rtl/elements_pkg.sv | 5 +
 rtl/my_fifo16.sv | 41 ++++
 rtl/my_dmux16_stream.sv | 48 ++++
 3 files changed

// File: rtl/elements_pkg.sv
// elements_pkg: shared word type and width for the 16-bit stream elements.
package elements_pkg;
    localparam int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/my_fifo16.sv
// my_fifo16: single-clock FIFO with registered storage; head reads 0 while empty.
module my_fifo16 import elements_pkg::*; #(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] occ;
    logic do_push, do_pop;
    // DEPTH is a power of two, so occupancy reaches DEPTH exactly when its MSB sets
    assign full = occ[AW];
    assign empty = occ == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push != do_pop) occ <= do_push ? occ + 1'b1 : occ - 1'b1;
        end
    end
endmodule

// File: rtl/my_dmux16_stream.sv
// my_dmux16_stream: 1-to-2 stream demux; each output buffered by its own FIFO
// so a stalled sink only blocks words steered to it.
module my_dmux16_stream import elements_pkg::*; #(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output word_t            count1,
    output word_t            count2
);
    logic full1, full2, empty1, empty2, push1, push2, pop1, pop2;
    // ready looks only at registered fullness: no pass-through on a full FIFO
    assign in_ready = in_sel ? !full2 : !full1;
    assign push1 = in_valid && in_ready && !in_sel;
    assign push2 = in_valid && in_ready && in_sel;
    assign out1_valid = !empty1;
    assign out2_valid = !empty2;
    assign pop1 = out1_valid && out1_ready;
    assign pop2 = out2_valid && out2_ready;
    my_fifo16 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1), .din(in_data), .full(full1),
        .pop(pop1), .dout(out1_data), .empty(empty1)
    );
    my_fifo16 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk(clk), .rst(rst), .push(push2), .din(in_data), .full(full2),
        .pop(pop2), .dout(out2_data), .empty(empty2)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count1 <= '0;
            count2 <= '0;
        end else begin
            if (pop1) count1 <= count1 + 1'b1;
            if (pop2) count2 <= count2 + 1'b1;
        end
    end
endmodule
